// File: rtl/branch_resolver.sv
// In-order branch resolution queue: matches fetch-time predictions against commit outcomes,
// drives the 2-bit predictor update port and raises a one-cycle flush with redirect PC on mispredict.
module branch_resolver #(
    parameter int DEPTH       = 8,
    parameter int PTR_WIDTH   = 3,
    parameter int LOCAL_WIDTH = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   pred_valid_in,
    input  logic                   pred_taken_in,
    input  logic [31:0]            pred_pc_in,
    input  logic [31:0]            pred_target_in,
    output logic                   pred_ready_out,
    input  logic                   res_valid_in,
    input  logic                   res_taken_in,
    input  logic [31:0]            res_target_in,
    output logic                   transition_signal,
    output logic                   branch,
    output logic [LOCAL_WIDTH-1:0] instr_addr,
    output logic                   flush_out,
    output logic [31:0]            redirect_pc_out,
    output logic [PTR_WIDTH:0]     count_out,
    output logic [15:0]            mispredict_cnt_out,
    output logic                   underflow_out
);

    localparam logic [PTR_WIDTH:0]   FULL    = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);

    logic                 ent_taken  [DEPTH];
    logic [31:0]          ent_pc     [DEPTH];
    logic [31:0]          ent_target [DEPTH];

    logic [PTR_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0] tail;
    logic [PTR_WIDTH:0]   count;

    logic                 not_empty;
    logic                 pop;
    logic                 push;
    logic                 mispredict;
    logic                 head_taken;
    logic [31:0]          head_pc;
    logic [31:0]          head_target;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] correct_pc(input logic taken, input logic [31:0] target,
                                               input logic [31:0] pc);
        return taken ? target : pc + 32'd4;
    endfunction

    assign not_empty   = (count != '0);
    assign head_taken  = ent_taken[head];
    assign head_pc     = ent_pc[head];
    assign head_target = ent_target[head];

    assign pop        = rdy_in & res_valid_in & not_empty;
    assign mispredict = pop & ((head_taken != res_taken_in) |
                               (res_taken_in & (head_target != res_target_in)));

    // A pop frees a slot in the same cycle, so a full queue still accepts a push.
    assign pred_ready_out = (count < FULL) | (res_valid_in & not_empty & rdy_in);
    // Pushes alongside a mispredicting pop belong to the wrong path and are dropped.
    assign push           = rdy_in & pred_valid_in & pred_ready_out & ~mispredict;
    assign count_out      = count;

    always_ff @(posedge clk_in) begin
        if (push) begin
            ent_taken[tail]  <= pred_taken_in;
            ent_pc[tail]     <= pred_pc_in;
            ent_target[tail] <= pred_target_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            transition_signal  <= 1'b0;
            branch             <= 1'b0;
            instr_addr         <= '0;
            flush_out          <= 1'b0;
            redirect_pc_out    <= '0;
            mispredict_cnt_out <= '0;
            underflow_out      <= 1'b0;
        end else begin
            transition_signal <= 1'b0;
            flush_out         <= 1'b0;
            if (pop) begin
                transition_signal <= 1'b1;
                branch            <= res_taken_in;
                instr_addr        <= head_pc[LOCAL_WIDTH+1:2];
            end
            if (mispredict) begin
                flush_out          <= 1'b1;
                redirect_pc_out    <= correct_pc(res_taken_in, res_target_in, head_pc);
                mispredict_cnt_out <= sat_inc(mispredict_cnt_out);
                head               <= '0;
                tail               <= '0;
                count              <= '0;
            end else begin
                if (pop)
                    head <= head + PTR_ONE;
                if (push)
                    tail <= tail + PTR_ONE;
                if (push && !pop)
                    count <= count + CNT_ONE;
                else if (pop && !push)
                    count <= count - CNT_ONE;
            end
            if (rdy_in && res_valid_in && !not_empty)
                underflow_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_branch_resolver;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        pred_valid_in;
    logic        pred_taken_in;
    logic [31:0] pred_pc_in;
    logic [31:0] pred_target_in;
    logic        pred_ready_out;
    logic        res_valid_in;
    logic        res_taken_in;
    logic [31:0] res_target_in;
    logic        transition_signal;
    logic        branch;
    logic [9:0]  instr_addr;
    logic        flush_out;
    logic [31:0] redirect_pc_out;
    logic [3:0]  count_out;
    logic [15:0] mispredict_cnt_out;
    logic        underflow_out;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_resolver #(.DEPTH(8), .PTR_WIDTH(3), .LOCAL_WIDTH(10)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pred_valid_in(pred_valid_in), .pred_taken_in(pred_taken_in),
        .pred_pc_in(pred_pc_in), .pred_target_in(pred_target_in),
        .pred_ready_out(pred_ready_out),
        .res_valid_in(res_valid_in), .res_taken_in(res_taken_in),
        .res_target_in(res_target_in),
        .transition_signal(transition_signal), .branch(branch), .instr_addr(instr_addr),
        .flush_out(flush_out), .redirect_pc_out(redirect_pc_out), .count_out(count_out),
        .mispredict_cnt_out(mispredict_cnt_out), .underflow_out(underflow_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        pv;
        logic        pt;
        logic [31:0] ppc;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        e_trans;
        logic        e_branch;
        logic [9:0]  e_addr;
        logic        e_flush;
        logic [31:0] e_redir;
        logic [15:0] e_mcnt;
        logic [3:0]  e_count;
        logic        e_uf;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic pv, input logic pt, input logic [31:0] ppc,
                         input logic [31:0] ptg, input logic rv, input logic rt,
                         input logic [31:0] rtg);
        rdy_in = rdy; pred_valid_in = pv; pred_taken_in = pt; pred_pc_in = ppc;
        pred_target_in = ptg; res_valid_in = rv; res_taken_in = rt; res_target_in = rtg;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_one(input logic pt, input logic [31:0] ppc, input logic [31:0] ptg);
        drive(1'b1, 1'b1, pt, ppc, ptg, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
    endtask

    function automatic logic [9:0] idx(input logic [31:0] pc);
        return pc[11:2];
    endfunction

    vec_t vecs[8];
    ent_t q[$];

    initial begin
        vecs[0] = '{1,1,32'h1000,32'h1040, 0,0,32'h0,    0,0,10'h000,0,32'h0,   16'd0,4'd1,0};
        vecs[1] = '{0,0,32'h0,   32'h0,    1,1,32'h1040, 1,1,10'h000,0,32'h0,   16'd0,4'd0,0};
        vecs[2] = '{1,0,32'h2004,32'h0,    0,0,32'h0,    0,0,10'h000,0,32'h0,   16'd0,4'd1,0};
        vecs[3] = '{0,0,32'h0,   32'h0,    1,0,32'h0,    1,0,10'h001,0,32'h0,   16'd0,4'd0,0};
        vecs[4] = '{1,0,32'h2008,32'h0,    0,0,32'h0,    0,0,10'h000,0,32'h0,   16'd0,4'd1,0};
        vecs[5] = '{0,0,32'h0,   32'h0,    1,1,32'h3000, 1,1,10'h002,1,32'h3000,16'd1,4'd0,0};
        vecs[6] = '{1,1,32'h4000,32'h4100, 0,0,32'h0,    0,0,10'h000,0,32'h0,   16'd1,4'd1,0};
        vecs[7] = '{0,0,32'h0,   32'h0,    1,0,32'h0,    1,0,10'h000,1,32'h4004,16'd2,4'd0,0};
        vecs[1].e_addr = 10'h000 | idx(32'h1000);

        // Reset state
        rst_in = 1'b0;
        idle();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_trans", 32'(transition_signal), 0);
        chk("rst_flush", 32'(flush_out), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_mcnt", 32'(mispredict_cnt_out), 0);
        chk("rst_uf", 32'(underflow_out), 0);
        chk("rst_redir", redirect_pc_out, 0);
        chk("rst_branch", 32'(branch), 0);
        chk("rst_addr", 32'(instr_addr), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        chk("ready_after_rst", 32'(pred_ready_out), 1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].pv, vecs[i].pt, vecs[i].ppc, vecs[i].ptg,
                  vecs[i].rv, vecs[i].rt, vecs[i].rtg);
            tick();
            idle();
            chk($sformatf("v%0d_trans", i), 32'(transition_signal), 32'(vecs[i].e_trans));
            chk($sformatf("v%0d_flush", i), 32'(flush_out), 32'(vecs[i].e_flush));
            chk($sformatf("v%0d_count", i), 32'(count_out), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_mcnt", i), 32'(mispredict_cnt_out), 32'(vecs[i].e_mcnt));
            chk($sformatf("v%0d_uf", i), 32'(underflow_out), 32'(vecs[i].e_uf));
            if (vecs[i].e_trans) begin
                chk($sformatf("v%0d_branch", i), 32'(branch), 32'(vecs[i].e_branch));
                chk($sformatf("v%0d_addr", i), 32'(instr_addr), 32'(vecs[i].e_addr));
            end
            if (vecs[i].e_flush)
                chk($sformatf("v%0d_redir", i), redirect_pc_out, vecs[i].e_redir);
        end
        tick();
        chk("pulse_clear_trans", 32'(transition_signal), 0);
        chk("pulse_clear_flush", 32'(flush_out), 0);

        // Fill to full, dropped push, push+pop while full, drain across pointer wrap
        for (int i = 0; i < 8; i++)
            push_one(1'b0, 32'h100 + 32'(4 * i), 32'h0);
        chk("full_count", 32'(count_out), 8);
        chk("full_ready", 32'(pred_ready_out), 0);
        drive(1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("full_push_ready", 32'(pred_ready_out), 0);
        tick();
        idle();
        chk("dropped_count", 32'(count_out), 8);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("full_pushpop_ready", 32'(pred_ready_out), 1);
        tick();
        idle();
        chk("pushpop_count", 32'(count_out), 8);
        chk("pushpop_trans", 32'(transition_signal), 1);
        chk("pushpop_addr", 32'(instr_addr), 32'(idx(32'h100)));
        for (int i = 0; i < 8; i++) begin
            logic [31:0] epc;
            epc = (i < 7) ? 32'h104 + 32'(4 * i) : 32'h200;
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            tick();
            idle();
            chk($sformatf("drain%0d_trans", i), 32'(transition_signal), 1);
            chk($sformatf("drain%0d_addr", i), 32'(instr_addr), 32'(idx(epc)));
            chk($sformatf("drain%0d_flush", i), 32'(flush_out), 0);
        end
        chk("drained_count", 32'(count_out), 0);

        // Squash on mispredict with same-cycle push, then underflow
        push_one(1'b0, 32'h300, 32'h0);
        push_one(1'b0, 32'h304, 32'h0);
        push_one(1'b0, 32'h308, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h30C, 32'h0, 1'b1, 1'b1, 32'h700);
        tick();
        idle();
        chk("squash_flush", 32'(flush_out), 1);
        chk("squash_trans", 32'(transition_signal), 1);
        chk("squash_redir", redirect_pc_out, 32'h700);
        chk("squash_mcnt", 32'(mispredict_cnt_out), 3);
        chk("squash_count", 32'(count_out), 0);
        tick();
        chk("squash_flush_clr", 32'(flush_out), 0);
        chk("squash_count2", 32'(count_out), 0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        chk("uf_trans", 32'(transition_signal), 0);
        chk("uf_set", 32'(underflow_out), 1);
        tick();
        chk("uf_sticky", 32'(underflow_out), 1);

        // rdy_in low stalls everything
        push_one(1'b0, 32'h500, 32'h0);
        push_one(1'b0, 32'h504, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h508, 32'h0, 1'b1, 1'b1, 32'h999);
            tick();
            chk($sformatf("stall%0d_trans", i), 32'(transition_signal), 0);
            chk($sformatf("stall%0d_flush", i), 32'(flush_out), 0);
            chk($sformatf("stall%0d_count", i), 32'(count_out), 2);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        chk("after_stall_addr", 32'(instr_addr), 32'(idx(32'h500)));
        chk("after_stall_count", 32'(count_out), 1);

        // Asynchronous reset mid-stream
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_count", 32'(count_out), 0);
        chk("async_uf", 32'(underflow_out), 0);
        chk("async_mcnt", 32'(mispredict_cnt_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();

        // Randomized traffic against the queue model
        begin
            logic        m_trans, m_branch, m_flush, m_uf, m_ready;
            logic [9:0]  m_addr;
            logic [31:0] m_redir;
            logic [15:0] m_mcnt;
            logic        rdy, pv, pt, rv, rt, mis;
            logic [31:0] ppc, ptg, rtg;
            ent_t        e;
            q.delete();
            m_trans = 0; m_branch = 0; m_flush = 0; m_uf = 0; m_addr = 0; m_redir = 0; m_mcnt = 0;
            for (int i = 0; i < 1500; i++) begin
                rdy = ($urandom_range(0, 9) != 0);
                pv  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
                rv  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 6);
                pt  = 1'($urandom_range(0, 1));
                ppc = {$urandom() >> 2, 2'b00};
                ptg = ppc + (($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80);
                if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
                    rt  = q[0].taken;
                    rtg = q[0].target;
                end else begin
                    rt  = 1'($urandom_range(0, 1));
                    rtg = {$urandom() >> 2, 2'b00};
                end
                drive(rdy, pv, pt, ppc, ptg, rv, rt, rtg);
                m_ready = (q.size() < 8) || (rv && q.size() != 0 && rdy);
                #1;
                chk($sformatf("rnd%0d_ready", i), 32'(pred_ready_out), 32'(m_ready));

                m_trans = 0;
                m_flush = 0;
                mis = 0;
                if (rdy) begin
                    if (rv && q.size() != 0) begin
                        e = q.pop_front();
                        m_trans  = 1;
                        m_branch = rt;
                        m_addr   = idx(e.pc);
                        mis = (e.taken != rt) || (rt && e.target != rtg);
                        if (mis) begin
                            m_flush = 1;
                            m_redir = rt ? rtg : e.pc + 32'd4;
                            if (m_mcnt != 16'hFFFF) m_mcnt++;
                            q.delete();
                        end
                    end else if (rv) begin
                        m_uf = 1;
                    end
                    if (pv && m_ready && !mis)
                        q.push_back('{pt, ppc, ptg});
                end
                tick();
                chk($sformatf("rnd%0d_trans", i), 32'(transition_signal), 32'(m_trans));
                chk($sformatf("rnd%0d_flush", i), 32'(flush_out), 32'(m_flush));
                chk($sformatf("rnd%0d_count", i), 32'(count_out), 32'(q.size()));
                chk($sformatf("rnd%0d_mcnt", i), 32'(mispredict_cnt_out), 32'(m_mcnt));
                chk($sformatf("rnd%0d_uf", i), 32'(underflow_out), 32'(m_uf));
                chk($sformatf("rnd%0d_branch", i), 32'(branch), 32'(m_branch));
                chk($sformatf("rnd%0d_addr", i), 32'(instr_addr), 32'(m_addr));
                chk($sformatf("rnd%0d_redir", i), redirect_pc_out, m_redir);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
